// File: rtl/block_avg_round_div_if.sv
// Stream interface for the block-average decimator: input beats, run-time
// controls, rounded output beats and the partial-block beat count.
interface block_avg_round_div_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_LOG2   = 2
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic [1:0]            mode;
  logic                  clear;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [DIV_LOG2-1:0]   beat_cnt;

  // Source/sink side: drives samples and controls, consumes results.
  modport master (
    output din, din_valid, mode, clear, dout_ready,
    input  din_ready, dout, dout_valid, beat_cnt
  );

  // Decimator side.
  modport slave (
    input  din, din_valid, mode, clear, dout_ready,
    output din_ready, dout, dout_valid, beat_cnt
  );
endinterface

// File: rtl/block_avg_round_div.sv
// Streaming block-average decimator: sums 2**DIV_LOG2 accepted beats and
// emits their mean, rounded by a run-time selectable mode, one cycle after
// the final beat of each block.
module block_avg_round_div #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  block_avg_round_div_if.slave  bus
);

  localparam int unsigned AccWidth = DATA_WIDTH + DIV_LOG2;
  localparam int unsigned HalfInt  = 1 << (DIV_LOG2 - 1);
  localparam logic [DIV_LOG2-1:0] Half = DIV_LOG2'(HalfInt);

  localparam logic [1:0] ModeTrunc    = 2'd0;
  localparam logic [1:0] ModeHalfEven = 2'd2;

  logic [AccWidth-1:0]   acc_q, acc_d;
  logic [DIV_LOG2-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  logic                  din_ready;
  logic                  accept;
  logic                  drain;
  logic                  final_beat;

  logic [AccWidth-1:0]   sum;
  logic [DATA_WIDTH-1:0] quot;
  logic [DIV_LOG2-1:0]   rem;
  logic                  round_up;
  logic [DATA_WIDTH:0]   rounded;
  logic [DATA_WIDTH-1:0] result;

  // Handshakes: a held result only blocks input while downstream stalls.
  always_comb begin
    din_ready  = ~dout_valid_q | bus.dout_ready;
    accept     = bus.din_valid & din_ready;
    drain      = dout_valid_q & bus.dout_ready;
    final_beat = &beat_cnt_q;
  end

  // Full-width block sum and its rounded mean for the current mode.
  always_comb begin
    sum      = acc_q + AccWidth'(bus.din);
    quot     = sum[AccWidth-1:DIV_LOG2];
    rem      = sum[DIV_LOG2-1:0];
    round_up = 1'b0;
    case (bus.mode)
      ModeTrunc:    round_up = 1'b0;
      ModeHalfEven: round_up = (rem > Half) | ((rem == Half) & quot[0]);
      default:      round_up = (rem >= Half);  // modes 1 and 3 are both half-up
    endcase
    rounded = {1'b0, quot} + (DATA_WIDTH + 1)'(round_up);
    // Overflow cannot occur for legal means; saturate defensively anyway.
    result  = rounded[DATA_WIDTH] ? '1 : rounded[DATA_WIDTH-1:0];
  end

  // Next state: clear beats any accept; a final-beat load overrides a drain.
  always_comb begin
    acc_d        = acc_q;
    beat_cnt_d   = beat_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (drain) begin
      dout_valid_d = 1'b0;
    end
    if (bus.clear) begin
      acc_d      = '0;
      beat_cnt_d = '0;
    end else if (accept) begin
      if (final_beat) begin
        acc_d        = '0;
        beat_cnt_d   = '0;
        dout_d       = result;
        dout_valid_d = 1'b1;
      end else begin
        acc_d      = sum;
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      beat_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      beat_cnt_q   <= beat_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Drive interface outputs.
  always_comb begin
    bus.din_ready  = din_ready;
    bus.dout       = dout_q;
    bus.dout_valid = dout_valid_q;
    bus.beat_cnt   = beat_cnt_q;
  end

endmodule
